fetch_pc_unit: RTL

Program-counter and fetch-sequencing stage that sits directly downstream of the jump-target mux. Each cycle it takes the resolved 16-bit branch target from the mux and decides the next fetch address: sequential increment, taken branch, stall hold or halt. It drives the instruction-memory address. It inserts a one-cycle squash bubble after every taken branch. It also reports run/halt status and a fetch count to the test harness.

---
 rtl/fetch_pc_unit.sv | 104 ++++++++++
 1 files changed

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - program counter and fetch sequencing with branch squash bubble
// Chooses sequential, branch, stall-hold or halt for the next fetch address each cycle.
module fetch_pc_unit #(
    parameter int              PC_W       = 16,
    parameter logic [PC_W-1:0] START_ADDR = '0,
    parameter logic [PC_W-1:0] MAX_ADDR   = 16'hFFFF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            stall,
    input  logic            branch_en,
    input  logic [PC_W-1:0] target,
    input  logic            halt_req,
    output logic [PC_W-1:0] pc,
    output logic            pc_valid,
    output logic            halted,
    output logic            done,
    output logic [15:0]     fetch_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     count_q, count_d;
    logic [15:0]     count_inc;
    logic            done_q, done_d;

    assign count_inc = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    pc_d    = START_ADDR;
                    count_d = '0;
                end
            end
            S_RUN: begin
                // Stall outranks branch: upstream keeps branch_en/target until release.
                if (halt_req) begin
                    state_d = S_HALT;
                    done_d  = 1'b1;
                end else if (stall) begin
                    state_d = S_RUN;
                end else if (branch_en) begin
                    state_d = S_FLUSH;
                    pc_d    = target;
                    count_d = count_inc;
                end else if (pc_q == MAX_ADDR) begin
                    state_d = S_HALT;
                    done_d  = 1'b1;
                    count_d = count_inc;
                end else begin
                    pc_d    = pc_q + 1'b1;
                    count_d = count_inc;
                end
            end
            S_FLUSH: begin
                state_d = S_RUN;
            end
            S_HALT: begin
                if (start) begin
                    state_d = S_RUN;
                    pc_d    = START_ADDR;
                    count_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= START_ADDR;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign pc          = pc_q;
    assign pc_valid    = (state_q == S_RUN);
    assign halted      = (state_q == S_HALT);
    assign done        = done_q;
    assign fetch_count = count_q;

endmodule
